// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetch and MEM data accesses; at most one transaction in flight.
// Latency: requester req to mem_req is 1 cycle; mem_rvalid to requester rvalid is 1 cycle (registered).
// Backpressure: requesters hold req until gnt and see stall_if/stall_mem; mem_* stays stable until mem_gnt.
// Optional feature: define ARB_STARVE_GUARD_EN so IF wins once after STARVE_MAX consecutive MEM grants.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction fetch requester
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    // data-memory requester
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [3:0]      dm_be,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    // shared memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    // pipeline stalls
    output logic            stall_if,
    output logic            stall_mem
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            drop_if_q, drop_if_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            dm_rvalid_q, dm_rvalid_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;

    logic            if_ok;
    logic            starve_hit;
    logic            grant_if, grant_dm;

    // A flushed fetch request is never granted in the cycle of the flush.
    assign if_ok = if_req & ~if_flush;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == CW'(STARVE_MAX));

    // Count MEM grants won while IF was waiting; saturates so a flushed IF cannot wrap it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_IDLE) begin
            if (!if_req || grant_if) begin
                starve_cnt_d = '0;
            end else if (grant_dm && !starve_hit) begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Guard compiled out: the comparison is constant false, so MEM always has priority.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    // Arbitration in IDLE: MEM (older instruction) wins unless the starvation guard fires.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
            if (dm_req && if_ok && starve_hit) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end else if (if_ok) begin
                grant_if = 1'b1;
            end
        end
    end

    // Next-state logic: capture winner into mem_*, wait for accept, then route the response.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_if_d   = drop_if_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                drop_if_d = 1'b0;
                owner_d   = OWN_NONE;
                if (grant_dm) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_we ? dm_be : 4'b0000;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (grant_if) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b0000;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            ST_REQ: begin
                if (owner_q == OWN_IF && if_flush) begin
                    drop_if_d = 1'b1;
                end
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner_q == OWN_IF && if_flush) begin
                    drop_if_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d   = ST_IDLE;
                    owner_d   = OWN_NONE;
                    drop_if_d = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_rdata;
                    end else if (!(drop_if_q || if_flush)) begin
                        // A flush in the response cycle itself also discards the fetch.
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            drop_if_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_if_q   <= drop_if_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // A requester stalls while waiting for its grant and from its grant until its response,
    // including a flushed fetch whose response is still draining from memory.
    assign stall_if  = rst_n & ((if_req & ~grant_if) | grant_if | (owner_q == OWN_IF));
    assign stall_mem = rst_n & ((dm_req & ~grant_dm) | grant_dm | (owner_q == OWN_DM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk, rst_n;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem;

    mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // owner: 0 none, 1 fetch, 2 data. issued: request on the bus, not yet accepted.
    int          m_owner  = 0;
    bit          m_issued = 0;
    bit          m_drop   = 0;
    bit          m_clean  = 1;
    int          m_dm_run = 0;
    bit          m_we     = 0;
    logic [3:0]  m_be     = '0;
    logic [31:0] m_addr   = '0, m_wdata = '0;
    bit          m_if_rv  = 0, m_dm_rv = 0;
    logic [31:0] m_if_rd  = '0, m_dm_rd = '0;

    // Who the rules say is granted this cycle (0 none, 1 fetch, 2 data).
    function automatic int winner();
        bit fetch_ok;
        if (rst_n !== 1'b1 || m_owner != 0) return 0;
        fetch_ok = (if_req === 1'b1) && (if_flush !== 1'b1);
        if (GUARD && dm_req === 1'b1 && fetch_ok && m_dm_run >= 4) return 1;
        if (dm_req === 1'b1) return 2;
        if (fetch_ok) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int w;
        w = winner();
        m_if_rv = 0;
        m_dm_rv = 0;
        if (rst_n !== 1'b1) begin
            m_owner = 0; m_issued = 0; m_drop = 0; m_clean = 1; m_dm_run = 0;
            m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
        end else if (m_owner == 0) begin
            if (w != 0) m_clean = 0;
            if (!if_req || w == 1) m_dm_run = 0;
            else if (w == 2 && m_dm_run < 4) m_dm_run++;
            if (w == 2) begin
                m_owner = 2; m_issued = 1; m_addr = dm_addr; m_we = dm_we;
                m_be = dm_we ? dm_be : 4'b0000; m_wdata = dm_wdata;
            end else if (w == 1) begin
                m_owner = 1; m_issued = 1; m_addr = if_addr; m_we = 0; m_be = 4'b0000; m_wdata = '0;
            end
        end else begin
            if (m_owner == 1 && if_flush) m_drop = 1;
            if (m_issued) begin
                if (mem_gnt) m_issued = 0;
            end else if (mem_rvalid) begin
                if (m_owner == 2) begin
                    m_dm_rv = 1; m_dm_rd = mem_rdata;
                end else if (!m_drop) begin
                    m_if_rv = 1; m_if_rd = mem_rdata;
                end
                m_owner = 0;
                m_drop  = 0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        int w;
        bit e_sif, e_smem;
        w = winner();
        e_sif  = (rst_n === 1'b1) && (((if_req === 1'b1) && w != 1) || w == 1 || m_owner == 1);
        e_smem = (rst_n === 1'b1) && (((dm_req === 1'b1) && w != 2) || w == 2 || m_owner == 2);
        chk("if_gnt", if_gnt, w == 1);
        chk("dm_gnt", dm_gnt, w == 2);
        chk("stall_if", stall_if, e_sif);
        chk("stall_mem", stall_mem, e_smem);
        chk("mem_req", mem_req, m_issued);
        if (m_issued) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_rvalid", if_rvalid, m_if_rv);
        chk("dm_rvalid", dm_rvalid, m_dm_rv);
        if (m_if_rv) chk("if_rdata", if_rdata, m_if_rd);
        if (m_dm_rv) chk("dm_rdata", dm_rdata, m_dm_rd);
        if (m_clean) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
            chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    bit          r_busy = 0;
    int          r_cnt  = 0;
    logic [31:0] r_data = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory that accepts after a random wait and answers 1..3 cycles after accepting.
    task automatic mem_step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (r_busy) begin
            if (r_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = r_data;
                r_busy     = 0;
            end else begin
                r_cnt--;
            end
        end else if (mem_req && $urandom_range(0, 1) == 1) begin
            mem_gnt = 1'b1;
            r_busy  = 1;
            r_cnt   = $urandom_range(0, 2);
            r_data  = $urandom();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 0; dm_req = 0; if_flush = 0; mem_gnt = 0; mem_rvalid = 0;
        r_busy = 0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit gi, gd;
        int n_g, n_ifg, cyc;
        rst_n = 0; if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        tick(); tick();
        #1;
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_rvalids", {if_rvalid, dm_rvalid}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Lone fetch.
        if_req = 1; if_addr = 32'h100; #1;
        chk("lone_gnt_c0", if_gnt, 1'b1);
        chk("lone_stall_c0", stall_if, 1'b1);
        tick(); if_req = 0; #1;
        chk("lone_mem_req_c1", mem_req, 1'b1);
        chk("lone_mem_addr_c1", mem_addr, 32'h100);
        tick(); mem_gnt = 1; #1;
        chk("lone_stall_c2", stall_if, 1'b1);
        tick(); mem_gnt = 0;
        tick(); mem_rvalid = 1; mem_rdata = 32'h0000_0013; #1;
        chk("lone_stall_c4", stall_if, 1'b1);
        tick(); mem_rvalid = 0; #1;
        chk("lone_rvalid_c5", if_rvalid, 1'b1);
        chk("lone_rdata_c5", if_rdata, 32'h13);
        chk("lone_stall_c5", stall_if, 1'b0);
        tick();

        // Collision: data load wins, fetch granted in the IDLE cycle after dm_rvalid.
        if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h2000; #1;
        chk("coll_dm_gnt", dm_gnt, 1'b1);
        chk("coll_if_gnt", if_gnt, 1'b0);
        tick(); dm_req = 0; mem_gnt = 1; #1;
        chk("coll_mem_addr", mem_addr, 32'h2000);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
        tick(); mem_rvalid = 0; #1;
        chk("coll_dm_rvalid", dm_rvalid, 1'b1);
        chk("coll_dm_rdata", dm_rdata, 32'hCAFE_0001);
        chk("coll_if_gnt_late", if_gnt, 1'b1);
        tick(); if_req = 0; mem_gnt = 1; #1;
        chk("coll_if_addr", mem_addr, 32'h104);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
        tick(); mem_rvalid = 0; #1;
        chk("coll_if_rdata", if_rdata, 32'h0BAD_F00D);
        tick();

        // Store.
        dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h3000; dm_wdata = 32'hDEAD_BEEF; #1;
        chk("st_gnt", dm_gnt, 1'b1);
        tick(); dm_req = 0; dm_we = 0; mem_gnt = 1; #1;
        chk("st_mem_we", mem_we, 1'b1);
        chk("st_mem_be", mem_be, 4'b0011);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        tick(); mem_rvalid = 0; #1;
        chk("st_ack", dm_rvalid, 1'b1);
        chk("st_no_if_rvalid", if_rvalid, 1'b0);
        tick();

        // Flush while waiting for the fetch response.
        if_req = 1; if_addr = 32'h200;
        tick(); if_req = 0; mem_gnt = 1;
        tick(); mem_gnt = 0; if_flush = 1;
        tick(); if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        tick(); mem_rvalid = 0; if_req = 1; if_addr = 32'h204; #1;
        chk("fl_no_rvalid", if_rvalid, 1'b0);
        chk("fl_regrant", if_gnt, 1'b1);
        tick(); if_req = 0; mem_gnt = 1;
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h2222_2222;
        tick(); mem_rvalid = 0; #1;
        chk("fl_next_rvalid", if_rvalid, 1'b1);
        chk("fl_next_rdata", if_rdata, 32'h2222_2222);
        tick();

        // Reset during WAIT, then a late response.
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
        tick(); dm_req = 0; mem_gnt = 1;
        tick(); mem_gnt = 0; rst_n = 0;
        tick(); rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h77; #1;
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_stall", {stall_if, stall_mem}, 2'b00);
        tick(); mem_rvalid = 0; #1;
        chk("rst_mid_no_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
        chk("rst_mid_mem_addr", mem_addr, 32'h0);
        tick();

        // Both requesters held continuously.
        do_reset();
        if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h5000;
        n_g = 0; n_ifg = 0; cyc = 0;
        while (n_g < 10 && cyc < 400) begin
            @(negedge clk);
            gi = if_gnt; gd = dm_gnt;
            if (gi || gd) begin
                chk("starve_seq", gi, GUARD && (n_g % 5 == 4));
                n_g++;
                if (gi) n_ifg++;
            end
            tick();
            mem_step();
            cyc++;
        end
        chk("starve_grants_done", n_g, 10);
        chk("starve_if_count", n_ifg, GUARD ? 2 : 0);

        // Randomized traffic.
        do_reset();
        gi = 0; gd = 0;
        repeat (3000) begin
            @(negedge clk);
            gi = if_gnt; gd = dm_gnt;
            tick();
            mem_step();
            if (gi) if_req = 0;
            if (gd) dm_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom() & 32'h0000_FFFC;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(0, 1); dm_be = 4'($urandom_range(0, 15));
                dm_addr = $urandom() & 32'h000F_FFFC; dm_wdata = $urandom();
            end
            if_flush = ($urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
